// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives the PC enable and the enable/flush pair
// of every pipeline latch. It resolves load-use stalls, taken-branch squashes,
// I-/D-memory wait states and the halt drain, and counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic                   dmemREN_MEM,
  input  logic                   dmemWEN_MEM,
  input  logic                   memtoReg_EX,
  input  logic [4:0]             final_wsel_EX,
  input  logic [4:0]             rs_ID,
  input  logic [4:0]             rt_ID,
  input  logic                   uses_rt_ID,
  input  logic                   branch_taken_EX,
  input  logic                   halt_ID,
  input  logic                   halt_WB,
  output logic                   pc_en,
  output logic                   en_ifid,
  output logic                   en_idex,
  output logic                   en_exmem,
  output logic                   en_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   flush_exmem,
  output logic                   flush_memwb,
  output logic                   halt_out,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] RUN        = 2'b00;
  localparam logic [1:0] MEM_WAIT   = 2'b01;
  localparam logic [1:0] HALT_DRAIN = 2'b10;
  localparam logic [1:0] HALTED     = 2'b11;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       dwait;
  logic       lu;

  assign dwait = (dmemREN_MEM | dmemWEN_MEM) & ~dhit;
  assign lu    = memtoReg_EX & (final_wsel_EX != 5'd0) &
                 ((final_wsel_EX == rs_ID) | (uses_rt_ID & (final_wsel_EX == rt_ID)));

  assign state_dbg = state;

  // Per-cycle hazard resolution: latch controls and next FSM state
  always_comb begin
    pc_en       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    next_state  = state;
    case (state)
      RUN, MEM_WAIT: begin
        // MEM_WAIT re-runs the full RUN priority chain, so the release cycle
        // also honours branch, load-use, halt and I-miss.
        next_state = RUN;
        if (dwait) begin
          pc_en      = 1'b0;
          en_ifid    = 1'b0;
          en_idex    = 1'b0;
          en_exmem   = 1'b0;
          en_memwb   = 1'b0;
          next_state = MEM_WAIT;
        end else if (branch_taken_EX) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (lu) begin
          pc_en      = 1'b0;
          en_ifid    = 1'b0;
          flush_idex = 1'b1;
        end else if (halt_ID) begin
          pc_en      = 1'b0;
          flush_ifid = 1'b1;
          next_state = HALT_DRAIN;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          flush_ifid = 1'b1;
        end
        if (halt_WB) next_state = HALTED;
      end
      HALT_DRAIN: begin
        pc_en      = 1'b0;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (dwait) begin
          en_ifid  = 1'b0;
          en_idex  = 1'b0;
          en_exmem = 1'b0;
          en_memwb = 1'b0;
        end
        if (halt_WB) next_state = HALTED;
      end
      default: begin
        pc_en    = 1'b0;
        en_ifid  = 1'b0;
        en_idex  = 1'b0;
        en_exmem = 1'b0;
        en_memwb = 1'b0;
      end
    endcase
    if (RST) begin
      pc_en       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
      next_state  = RUN;
    end
  end

  // FSM state and sticky halt flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      halt_out <= 1'b0;
    end else begin
      state    <= next_state;
      halt_out <= (next_state == HALTED);
    end
  end

  // Saturating count of PC-stalled cycles while running or waiting on D-mem
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
    end else if (((state == RUN) || (state == MEM_WAIT)) && !pc_en &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table of single-cycle
// decisions from reset, plus sequences for D-wait, halt drain and saturation.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, ren, wen, m2r, urt, br, hid, hwb;
  logic [4:0]  wsel, rs, rt;

  logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic        fl_ifid, fl_idex, fl_exmem, fl_memwb;
  logic        halt_out;
  logic [15:0] stall_cycles;
  logic [1:0]  state_dbg;

  logic        pc_en4, en_ifid4, en_idex4, en_exmem4, en_memwb4;
  logic        fl_ifid4, fl_idex4, fl_exmem4, fl_memwb4;
  logic        halt_out4;
  logic [3:0]  stall_cycles4;
  logic [1:0]  state_dbg4;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.STALL_CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_MEM(ren), .dmemWEN_MEM(wen), .memtoReg_EX(m2r),
    .final_wsel_EX(wsel), .rs_ID(rs), .rt_ID(rt), .uses_rt_ID(urt),
    .branch_taken_EX(br), .halt_ID(hid), .halt_WB(hwb),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(fl_ifid), .flush_idex(fl_idex),
    .flush_exmem(fl_exmem), .flush_memwb(fl_memwb),
    .halt_out(halt_out), .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  pipeline_hazard_ctrl #(.STALL_CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_MEM(ren), .dmemWEN_MEM(wen), .memtoReg_EX(m2r),
    .final_wsel_EX(wsel), .rs_ID(rs), .rt_ID(rt), .uses_rt_ID(urt),
    .branch_taken_EX(br), .halt_ID(hid), .halt_WB(hwb),
    .pc_en(pc_en4), .en_ifid(en_ifid4), .en_idex(en_idex4),
    .en_exmem(en_exmem4), .en_memwb(en_memwb4),
    .flush_ifid(fl_ifid4), .flush_idex(fl_idex4),
    .flush_exmem(fl_exmem4), .flush_memwb(fl_memwb4),
    .halt_out(halt_out4), .stall_cycles(stall_cycles4), .state_dbg(state_dbg4)
  );

  typedef struct {
    string      name;
    logic       ihit, dhit, ren, wen, m2r;
    logic [4:0] wsel, rs, rt;
    logic       urt, br, hid, hwb;
    logic       exp_pc;
    logic [3:0] exp_en;
    logic [3:0] exp_fl;
    logic [1:0] exp_st;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic ih, logic dh, logic rn, logic wn,
                              logic mr, logic [4:0] ws, logic [4:0] s, logic [4:0] t,
                              logic ur, logic b, logic hi, logic hw, logic epc,
                              logic [3:0] een, logic [3:0] efl, logic [1:0] est);
    vec_t v;
    v.name = name; v.ihit = ih; v.dhit = dh; v.ren = rn; v.wen = wn; v.m2r = mr;
    v.wsel = ws; v.rs = s; v.rt = t; v.urt = ur; v.br = b; v.hid = hi; v.hwb = hw;
    v.exp_pc = epc; v.exp_en = een; v.exp_fl = efl; v.exp_st = est;
    v.exp_cnt = epc ? 16'd0 : 16'd1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; ren = 1'b0; wen = 1'b0; m2r = 1'b0;
    wsel = 5'd0; rs = 5'd0; rt = 5'd0; urt = 1'b0; br = 1'b0; hid = 1'b0; hwb = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk_ctl(string name, logic epc, logic [3:0] een, logic [3:0] efl);
    chk({name, ".pc_en"}, 32'(pc_en), 32'(epc));
    chk({name, ".en"}, 32'({en_ifid, en_idex, en_exmem, en_memwb}), 32'(een));
    chk({name, ".flush"}, 32'({fl_ifid, fl_idex, fl_exmem, fl_memwb}), 32'(efl));
  endtask

  initial begin
    RST = 1'b1;
    idle();

    //       name           ih dh rn wn mr wsel  rs    rt    ur br hi hw pc en       fl       st
    vecs.push_back(mk("idle",      1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, 1,4'b1111,4'b0000,2'b00));
    vecs.push_back(mk("lu_rs",     1,0,0,0,1, 5'd5, 5'd5, 5'd0, 0,0,0,0, 0,4'b0111,4'b0100,2'b00));
    vecs.push_back(mk("lu_rt",     1,0,0,0,1, 5'd7, 5'd3, 5'd7, 1,0,0,0, 0,4'b0111,4'b0100,2'b00));
    vecs.push_back(mk("zero_reg",  1,0,0,0,1, 5'd0, 5'd0, 5'd0, 1,0,0,0, 1,4'b1111,4'b0000,2'b00));
    vecs.push_back(mk("rt_unused", 1,0,0,0,1, 5'd7, 5'd3, 5'd7, 0,0,0,0, 1,4'b1111,4'b0000,2'b00));
    vecs.push_back(mk("not_load",  1,0,0,0,0, 5'd5, 5'd5, 5'd5, 1,0,0,0, 1,4'b1111,4'b0000,2'b00));
    vecs.push_back(mk("dwait_ld",  1,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, 0,4'b0000,4'b0000,2'b01));
    vecs.push_back(mk("dwait_st",  1,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, 0,4'b0000,4'b0000,2'b01));
    vecs.push_back(mk("dhit_ok",   1,1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, 1,4'b1111,4'b0000,2'b00));
    vecs.push_back(mk("br_wins",   0,0,0,0,1, 5'd5, 5'd5, 5'd0, 0,1,1,0, 1,4'b1111,4'b1100,2'b00));
    vecs.push_back(mk("dwait_br",  1,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,1,0,0, 0,4'b0000,4'b0000,2'b01));
    vecs.push_back(mk("dwait_lu",  1,0,0,1,1, 5'd9, 5'd9, 5'd0, 0,0,0,0, 0,4'b0000,4'b0000,2'b01));
    vecs.push_back(mk("halt_id",   1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,1,0, 0,4'b1111,4'b1000,2'b10));
    vecs.push_back(mk("imiss",     0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0, 0,4'b1111,4'b1000,2'b00));
    vecs.push_back(mk("halt_wb",   1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,1, 1,4'b1111,4'b0000,2'b11));
    vecs.push_back(mk("lu_halt",   1,0,0,0,1, 5'd4, 5'd4, 5'd0, 0,0,1,0, 0,4'b0111,4'b0100,2'b00));
    vecs.push_back(mk("lu_imiss",  0,0,0,0,1, 5'd6, 5'd1, 5'd6, 1,0,0,0, 0,4'b0111,4'b0100,2'b00));

    // reset outputs and state
    #1;
    chk_ctl("rst_out", 1'b0, 4'b0000, 4'b1111);
    tick();
    RST = 1'b0;
    chk("rst.state", 32'(state_dbg), 32'd0);
    chk("rst.halt_out", 32'(halt_out), 32'd0);
    chk("rst.stall", 32'(stall_cycles), 32'd0);

    // table: each vector is one decision cycle from a fresh RUN state
    foreach (vecs[i]) begin
      do_reset();
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; ren = vecs[i].ren; wen = vecs[i].wen;
      m2r = vecs[i].m2r; wsel = vecs[i].wsel; rs = vecs[i].rs; rt = vecs[i].rt;
      urt = vecs[i].urt; br = vecs[i].br; hid = vecs[i].hid; hwb = vecs[i].hwb;
      #1;
      chk_ctl(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_en, vecs[i].exp_fl);
      tick();
      chk({vecs[i].name, ".state"}, 32'(state_dbg), 32'(vecs[i].exp_st));
      chk({vecs[i].name, ".stall"}, 32'(stall_cycles), 32'(vecs[i].exp_cnt));
      chk({vecs[i].name, ".halt_out"}, 32'(halt_out), 32'(vecs[i].exp_st == 2'b11));
    end

    // load-use: single stall cycle, then full flow
    do_reset();
    m2r = 1'b1; wsel = 5'd5; rs = 5'd5;
    #1;
    chk_ctl("lu_seq.stall", 1'b0, 4'b0111, 4'b0100);
    tick();
    idle();
    #1;
    chk_ctl("lu_seq.after", 1'b1, 4'b1111, 4'b0000);
    chk("lu_seq.cnt", 32'(stall_cycles), 32'd1);

    // D-wait for three cycles, then release
    do_reset();
    ren = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("dw_seq.freeze%0d", i), 1'b0, 4'b0000, 4'b0000);
      tick();
      chk($sformatf("dw_seq.state%0d", i), 32'(state_dbg), 32'd1);
    end
    dhit = 1'b1;
    #1;
    chk_ctl("dw_seq.release", 1'b1, 4'b1111, 4'b0000);
    tick();
    chk("dw_seq.state_run", 32'(state_dbg), 32'd0);
    chk("dw_seq.cnt", 32'(stall_cycles), 32'd3);

    // D-wait released into a taken branch: branch is honoured on release
    do_reset();
    ren = 1'b1; br = 1'b1;
    tick();
    dhit = 1'b1;
    #1;
    chk_ctl("dw_br.release", 1'b1, 4'b1111, 4'b1100);

    // reset mid-wait
    do_reset();
    ren = 1'b1;
    tick();
    chk("rst_wait.in", 32'(state_dbg), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_wait.state", 32'(state_dbg), 32'd0);
    chk("rst_wait.cnt", 32'(stall_cycles), 32'd0);

    // halt drain: halt_WB three cycles after halt_ID
    do_reset();
    hid = 1'b1;
    tick();
    hid = 1'b0;
    chk("hd.state0", 32'(state_dbg), 32'd2);
    chk("hd.cnt0", 32'(stall_cycles), 32'd1);
    #1;
    chk_ctl("hd.drain1", 1'b0, 4'b1111, 4'b1100);
    tick();
    ren = 1'b1;
    #1;
    chk_ctl("hd.drain2_dwait", 1'b0, 4'b0000, 4'b1100);
    tick();
    chk("hd.state2", 32'(state_dbg), 32'd2);
    ren = 1'b0;
    hwb = 1'b1;
    #1;
    chk_ctl("hd.drain3", 1'b0, 4'b1111, 4'b1100);
    chk("hd.halt_pre", 32'(halt_out), 32'd0);
    tick();
    hwb = 1'b0;
    chk("hd.halted", 32'(state_dbg), 32'd3);
    chk("hd.halt_out", 32'(halt_out), 32'd1);
    chk("hd.cnt_frozen", 32'(stall_cycles), 32'd1);
    ihit = 1'b0; br = 1'b1; hid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("hd.hold%0d", i), 1'b0, 4'b0000, 4'b0000);
      tick();
      chk($sformatf("hd.sticky%0d", i), 32'(halt_out), 32'd1);
    end
    chk("hd.cnt_after", 32'(stall_cycles), 32'd1);
    idle();
    RST = 1'b1;
    #1;
    chk_ctl("hd.rst_out", 1'b0, 4'b0000, 4'b1111);
    tick();
    RST = 1'b0;
    chk("hd.rst_state", 32'(state_dbg), 32'd0);
    chk("hd.rst_halt", 32'(halt_out), 32'd0);

    // saturation on the narrow instance, 20 I-miss cycles
    do_reset();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat.narrow", 32'(stall_cycles4), 32'd15);
    chk("sat.wide", 32'(stall_cycles), 32'd20);
    tick();
    chk("sat.narrow_held", 32'(stall_cycles4), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Each cycle it drives every latch's enable/flush pair and pc_en, covering load-use stalls, taken-branch/jump squashes, I-/D-memory wait states and the halt drain.
- It tracks halt and D-wait in a small FSM and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- ihit  in  1  instruction memory returned valid instr this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- dmemREN_MEM  in  1  MEM-stage instruction is a load.
- dmemWEN_MEM  in  1  MEM-stage instruction is a store.
- memtoReg_EX  in  1  EX-stage instruction is a load.
- final_wsel_EX  in  5  destination register of the EX-stage instruction.
- rs_ID  in  5  ID-stage source register rs.
- rt_ID  in  5  ID-stage source register rt.
- uses_rt_ID  in  1  ID-stage instruction reads rt.
- branch_taken_EX  in  1  EX resolved a taken branch/jump; PC loads target.
- halt_ID  in  1  ID-stage instruction is halt.
- halt_WB  in  1  halt has reached WB.
- pc_en  out  1  PC register update enable.
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  latch enable (0 = hold).
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  latch clears to bubble on the edge, regardless of enable.
- halt_out  out  1  processor halted; sticky.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_en=0 while in RUN or MEM_WAIT.
- state_dbg  out  2  00 RUN, 01 MEM_WAIT, 10 HALT_DRAIN, 11 HALTED.

Behaviour:
- Reset (RST=1 at edge): state goes to RUN, halt_out=0, stall_cycles=0.
- Outputs while RST=1: pc_en=0, all en=0, all flush=1.
- Outputs are combinational from state and inputs. Only state, halt_out and stall_cycles are registered.
- Definitions:
  - dwait = (dmemREN_MEM|dmemWEN_MEM) & !dhit.
  - lu = memtoReg_EX & final_wsel_EX!=0 & (final_wsel_EX==rs_ID | (uses_rt_ID & final_wsel_EX==rt_ID)).
- RUN/MEM_WAIT decision. Default is all en=1, all flush=0, pc_en=1. The first matching rule wins:
  1. dwait: pc_en=0, all en=0. Next state is MEM_WAIT.
  2. branch_taken_EX: flush_ifid=1, flush_idex=1, pc_en=1. lu, halt_ID and !ihit are ignored this cycle (the ID instr is squashed).
  3. lu: pc_en=0, en_ifid=0, flush_idex=1. The bubble clears the hazard next cycle; there is no repeat stall.
  4. halt_ID: flush_ifid=1, pc_en=0. The halt advances into ID/EX. Next state is HALT_DRAIN.
  5. !ihit: pc_en=0, flush_ifid=1 (bubble into IF/ID); later stages advance.
- MEM_WAIT: rules are re-evaluated every cycle.
  - The cycle dhit rises evaluates as RUN, including rules 2-5.
  - Next state is RUN unless dwait persists.
- HALT_DRAIN:
  - pc_en=0 and flush_ifid=1 every cycle. flush_idex=1 once the halt has left ID/EX, i.e. every HALT_DRAIN cycle.
  - Downstream stages advance, but dwait still freezes EX/MEM and MEM/WB (en=0), ID/EX and IF/ID.
  - On halt_WB=1: next state is HALTED and halt_out is set the following edge.
- HALTED: pc_en=0, all en=0, all flush=0, halt_out=1. Held until RST.
- halt_WB observed in RUN/MEM_WAIT (halt entering without HALT_DRAIN) also forces HALTED.
- stall_cycles: increments on each edge where state∈{RUN,MEM_WAIT} and pc_en=0. It saturates at all-ones and is not incremented in HALT_DRAIN/HALTED.
- Simultaneous events:
  - dwait with branch_taken_EX: freeze; the branch is retaken on the release cycle because EX is held.
  - dwait with lu: freeze only.
  - RST mid-drain or mid-wait: RUN next edge, halt_out cleared.

Test Plan:
- Load-use: EX lw final_wsel_EX=5, ID rs_ID=5, ihit=1 -> one cycle of pc_en=0, en_ifid=0, flush_idex=1; next cycle back to all en=1; stall_cycles=1.
- Zero-reg / no-rt: final_wsel_EX=0 matching rs_ID=0, or rt match with uses_rt_ID=0 -> no stall.
- D-wait: dmemREN_MEM=1, dhit=0 for 3 cycles then 1 -> state_dbg=01 for 3 cycles with all en=0; release cycle all en=1; stall_cycles=3.
- Branch beats hazard: branch_taken_EX=1 with lu=1 and halt_ID=1 -> flush_ifid=flush_idex=1, pc_en=1, state stays RUN.
- Halt drain: halt_ID=1, then halt_WB=1 three cycles later -> HALT_DRAIN for 3 cycles; HALTED with halt_out=1 sticky; all en=0 afterwards; RST returns halt_out=0.
- Saturation: STALL_CNT_W=4 with 20 !ihit cycles -> stall_cycles=15 held.
